ring_tune_ctrl: RTL
===================

# ring_tune_ctrl

Digital controller that tunes one microring resonator of the WDM link onto its carrier wavelength. It sweeps a heater DAC code across its full range and reads the drop-port photodetector power through an ADC handshake at each code. It then parks the heater at the code that gave maximum power and monitors that power, relocking automatically if it sags. It sits between the per-ring heater DAC and the monitor-PD ADC, one instance per ring in the WDM bank.

## Interface
Parameters:
- `DAC_W`, 8: heater code width; sweep range 0 .. 2^DAC_W-1.
- `ADC_W`, 10: photodetector power code width (unsigned).
- `STEP`, 1: heater code increment per sweep point; must be ≥1.
- `SETTLE_CYC`, 4: cycles held after each heater change before sampling; must be ≥1.
- `MON_PERIOD`, 64: cycles between monitor samples while locked; must be ≥1.
- `LOCK_THRESH`, 16: allowed power drop below `peak_pwr` before lock is declared lost.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a full sweep.
- `abort`  in  1: return to IDLE from any state; has priority over `start`.
- `heater_code`  out  DAC_W: registered heater DAC code.
- `adc_req`  out  1: one-cycle sample request pulse.
- `adc_valid`  in  1: sample returned; honored only in WAIT and MON_WAIT.
- `adc_data`  in  ADC_W: power code, qualified by `adc_valid`.
- `busy`  out  1: high in SETTLE and WAIT.
- `locked`  out  1: high in LOCKED and MON_WAIT.
- `done`  out  1: one-cycle pulse on sweep completion.
- `lock_lost`  out  1: one-cycle pulse when monitor detects a power drop.
- `peak_code`  out  DAC_W: heater code of the best sample in the last sweep.
- `peak_pwr`  out  ADC_W: power code of the best sample in the last sweep.

## Operation
- States: IDLE, SETTLE, WAIT, LOCKED, MON_WAIT.
- Reset values: state IDLE, and every output at 0.
- IDLE → SETTLE on `start`:
  - `heater_code` ← 0, `peak_code` ← 0, `peak_pwr` ← 0.
  - Settle counter ← 0.
- SETTLE: count `SETTLE_CYC` cycles, then pulse `adc_req` for one cycle and enter WAIT.
- WAIT: hold until `adc_valid`. On that cycle:
  - If `adc_data` > `peak_pwr` (strict), capture `peak_pwr` ← `adc_data` and `peak_code` ← `heater_code`. Ties keep the earlier, lower code.
  - Next code = `heater_code` + `STEP`, computed DAC_W+1 bits wide.
  - If the next code is ≤ 2^DAC_W-1: load it into `heater_code` and go to SETTLE.
  - Otherwise the sweep is complete: go to LOCKED, load `heater_code` ← peak (using the value updated by this same sample), pulse `done`.
- There is no ADC timeout; WAIT holds indefinitely.
- LOCKED: a monitor counter counts `MON_PERIOD` cycles, then pulses `adc_req` and enters MON_WAIT.
- MON_WAIT, on `adc_valid`:
  - Compare `adc_data` + `LOCK_THRESH` < `peak_pwr`, evaluated ADC_W+1 bits wide.
  - If true: pulse `lock_lost` and restart the sweep exactly as for `start` (`locked` falls, `busy` rises).
  - Otherwise: return to LOCKED and reload the monitor counter.
- `start` in LOCKED or MON_WAIT restarts the sweep. `start` in SETTLE or WAIT is ignored.
- `abort` in any state:
  - Go to IDLE, `heater_code` ← 0, `locked` ← 0.
  - Drop any pending sample; no `done` or `lock_lost` pulse.
  - `peak_code` and `peak_pwr` hold their values.
- Reset asserted mid-operation clears everything immediately (asynchronous), including any `adc_req` pulse in flight.

## Timing
- `start` at cycle 0:
  - `heater_code` = 0 and `busy` = 1 from cycle 1.
  - `adc_req` pulses at cycle 1+`SETTLE_CYC`.
- Per sweep point: `SETTLE_CYC` + 1 + ADC latency cycles. With zero-wait ADC (`adc_valid` the cycle after `adc_req`), that is `SETTLE_CYC`+2.
- The new `heater_code` appears the cycle after the `adc_valid` that triggered it.
- `done`, `locked` = 1, and `heater_code` = `peak_code` all appear in the same cycle, one after the final `adc_valid`.
- First monitor `adc_req` comes `MON_PERIOD` cycles after entering LOCKED.
- `adc_valid` in IDLE, SETTLE, or LOCKED is ignored.

## Test plan
- Sweep with synthetic Lorentzian response:
  - Setup: DAC_W=8, STEP=1, model returns 1000 at code 137, falling off on both sides.
  - Required: 256 `adc_req` pulses, then `done`; `peak_code`=137, `peak_pwr`=1000, `heater_code`=137, `locked`=1.
- Tie and step overflow:
  - Setup: STEP=3, equal maximum power 500 at codes 30 and 60.
  - Required: `peak_code`=30; the last sampled code is 255; 86 samples total.
- Monitor relock:
  - Setup: after lock at `peak_pwr`=1000, THRESH=16.
  - Monitor returning 984 → stays locked.
  - Monitor returning 983 → `lock_lost` pulse; next cycle `heater_code`=0, `busy`=1; a full sweep follows.
- ADC backpressure:
  - Stimulus: delay `adc_valid` 20 cycles, and inject a spurious `adc_valid` during SETTLE.
  - Required: `heater_code` holds; the spurious sample is ignored; the peak result is unchanged.
- Abort and reset mid-sweep:
  - `abort` and `start` together in WAIT → IDLE, `heater_code`=0, no `done`.
  - `rst_n` low mid-SETTLE → all outputs 0 asynchronously.
- Restart while locked: `start` in LOCKED → `peak_pwr` clears to 0 and a new sweep completes with fresh results.

Source files
------------

// File: rtl/ring_tune_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ring_tune_ctrl_if : control, heater-DAC and monitor-ADC bundle of one ring |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface ring_tune_ctrl_if #(
  parameter int DAC_W = 8,
  parameter int ADC_W = 10
);
  logic             start;
  logic             abort;
  logic [DAC_W-1:0] heater_code;
  logic             adc_req;
  logic             adc_valid;
  logic [ADC_W-1:0] adc_data;
  logic             busy;
  logic             locked;
  logic             done;
  logic             lock_lost;
  logic [DAC_W-1:0] peak_code;
  logic [ADC_W-1:0] peak_pwr;

  // master is the tuning controller; slave is the ADC/host environment
  modport master (
    input  start, abort, adc_valid, adc_data,
    output heater_code, adc_req, busy, locked, done, lock_lost, peak_code, peak_pwr
  );

  modport slave (
    output start, abort, adc_valid, adc_data,
    input  heater_code, adc_req, busy, locked, done, lock_lost, peak_code, peak_pwr
  );
endinterface
`default_nettype wire

// File: rtl/ring_tune_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ring_tune_ctrl : sweeps a microring heater, parks it at peak drop power    |
// |                  and relocks automatically when the monitored power sags   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ring_tune_ctrl #(
  parameter int DAC_W       = 8,
  parameter int ADC_W       = 10,
  parameter int STEP        = 1,
  parameter int SETTLE_CYC  = 4,
  parameter int MON_PERIOD  = 64,
  parameter int LOCK_THRESH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ring_tune_ctrl_if.master bus
);

  localparam int c_CNT_MAX = (SETTLE_CYC > MON_PERIOD) ? SETTLE_CYC : MON_PERIOD;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_MON_LAST    = c_CNT_W'(MON_PERIOD - 1);
  localparam logic [DAC_W:0]     c_STEP        = (DAC_W + 1)'(STEP);
  localparam logic [ADC_W:0]     c_THRESH      = (ADC_W + 1)'(LOCK_THRESH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_WAIT     = 3'd2,
    S_LOCKED   = 3'd3,
    S_MON_WAIT = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DAC_W-1:0]   r_heater;
  logic               r_adc_req;
  logic               r_busy;
  logic               r_locked;
  logic               r_done;
  logic               r_lock_lost;
  logic [DAC_W-1:0]   r_peak_code;
  logic [ADC_W-1:0]   r_peak_pwr;

  logic               w_better;
  logic [DAC_W-1:0]   w_new_peak_code;
  logic [ADC_W-1:0]   w_new_peak_pwr;
  logic [DAC_W:0]     w_next_code;
  logic               w_sweep_end;
  logic               w_sag;
  logic               w_sag_hit;
  logic               w_restart;

  // Strict compare keeps the lowest code among equal-power samples
  assign w_better        = bus.adc_data > r_peak_pwr;
  assign w_new_peak_code = w_better ? r_heater : r_peak_code;
  assign w_new_peak_pwr  = w_better ? bus.adc_data : r_peak_pwr;
  assign w_next_code     = {1'b0, r_heater} + c_STEP;
  assign w_sweep_end     = w_next_code[DAC_W];

  assign w_sag     = ({1'b0, bus.adc_data} + c_THRESH) < {1'b0, r_peak_pwr};
  assign w_sag_hit = (r_state == S_MON_WAIT) && bus.adc_valid && w_sag;

  // start is honoured only outside an active sweep; a power sag relaunches too
  assign w_restart = (bus.start && (r_state == S_IDLE || r_state == S_LOCKED ||
                                    r_state == S_MON_WAIT)) || w_sag_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_heater    <= '0;
      r_adc_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_lock_lost <= 1'b0;
      r_peak_code <= '0;
      r_peak_pwr  <= '0;
    end else begin
      r_adc_req   <= 1'b0;
      r_done      <= 1'b0;
      r_lock_lost <= 1'b0;

      if (bus.abort) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_heater <= '0;
        r_busy   <= 1'b0;
        r_locked <= 1'b0;
      end else if (w_restart) begin
        r_state     <= S_SETTLE;
        r_cnt       <= '0;
        r_heater    <= '0;
        r_peak_code <= '0;
        r_peak_pwr  <= '0;
        r_busy      <= 1'b1;
        r_locked    <= 1'b0;
        r_lock_lost <= w_sag_hit;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
          end

          S_SETTLE: begin
            if (r_cnt == c_SETTLE_LAST) begin
              r_adc_req <= 1'b1;
              r_state   <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_WAIT: begin
            if (bus.adc_valid) begin
              r_peak_code <= w_new_peak_code;
              r_peak_pwr  <= w_new_peak_pwr;
              r_cnt       <= '0;
              if (w_sweep_end) begin
                r_state  <= S_LOCKED;
                r_heater <= w_new_peak_code;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_locked <= 1'b1;
              end else begin
                r_state  <= S_SETTLE;
                r_heater <= w_next_code[DAC_W-1:0];
              end
            end
          end

          S_LOCKED: begin
            if (r_cnt == c_MON_LAST) begin
              r_adc_req <= 1'b1;
              r_state   <= S_MON_WAIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_MON_WAIT: begin
            if (bus.adc_valid) begin
              r_state <= S_LOCKED;
              r_cnt   <= '0;
            end
          end

          default: begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_heater <= '0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.heater_code = r_heater;
  assign bus.adc_req     = r_adc_req;
  assign bus.busy        = r_busy;
  assign bus.locked      = r_locked;
  assign bus.done        = r_done;
  assign bus.lock_lost   = r_lock_lost;
  assign bus.peak_code   = r_peak_code;
  assign bus.peak_pwr    = r_peak_pwr;

endmodule
`default_nettype wire
